// File: rtl/nes_video_pkg.sv
// Shared NES-to-VGA timing constants and sync FSM state type.
// dim_pixel exists only when SCANLINE_DIM_EN is defined.
package nes_video_pkg;

  localparam logic [9:0] H_TOTAL      = 10'd682;
  localparam logic [9:0] V_TOTAL      = 10'd524;
  localparam logic [8:0] PPU_DOTS     = 9'd341;
  localparam logic [8:0] PPU_LINES    = 9'd262;
  localparam logic [9:0] MATCH_H_MIN  = 10'd674;
  localparam logic [8:0] PPU_VIS_W    = 9'd256;
  localparam logic [8:0] PPU_VIS_H    = 9'd240;
  localparam logic [8:0] FRAME_MARK_Y = 9'd1;

  typedef enum logic {
    ST_HUNT,
    ST_LOCKED
  } sync_state_e;

`ifdef SCANLINE_DIM_EN
  // Halve each 5-bit channel of a {B,G,R} pixel.
  function automatic logic [14:0] dim_pixel(input logic [14:0] px);
    return {1'b0, px[14:11], 1'b0, px[9:6], 1'b0, px[4:1]};
  endfunction
`endif

endpackage

// File: rtl/line_buffer_2x256.sv
// Two-bank 256-entry scanline buffer: simple dual-port 512x15 RAM,
// one write port and one registered read port (read returns old data on collision).
module line_buffer_2x256 (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [8:0]  waddr_i,
  input  logic [14:0] wdata_i,
  input  logic [8:0]  raddr_i,
  output logic [14:0] rdata_o
);

  logic [14:0] mem_q [0:511];
  logic [14:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  always_comb begin
    rdata_o = rdata_q;
  end

endmodule

// File: rtl/scanline_sync_ctrl.sv
// NES PPU to VGA line doubler with frame-lock supervision of the VGA driver.
// Optional macro SCANLINE_DIM_EN halves the brightness of odd VGA lines.
module scanline_sync_ctrl
  import nes_video_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ppu_ce,
  input  logic [8:0]  ppu_x,
  input  logic [8:0]  ppu_y,
  input  logic [14:0] ppu_pixel,
  input  logic [9:0]  vga_hcounter,
  input  logic [9:0]  vga_vcounter,
  input  logic [9:0]  next_pixel_x,
  output logic        sync,
  output logic [14:0] pixel,
  output logic        locked,
  output logic [7:0]  resync_count
);

  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [8:0]  rd_addr;
  logic [9:0]  vn;
  logic [14:0] rd_data;
  logic [14:0] pixel_d;
  logic        frame_mark;
  logic        match;
  logic        unused_bits;

  sync_state_e state_q;
  logic        sync_q;
  logic        locked_q;
  logic [1:0]  miss_q;
  logic [7:0]  resync_q;

  // Line address is looked up one cycle early, so the wrap column reads the next line.
  always_comb begin
    wr_en      = ppu_ce && (ppu_x < PPU_VIS_W) && (ppu_y < PPU_VIS_H);
    wr_addr    = {ppu_y[0], ppu_x[7:0]};
    vn         = (vga_hcounter == H_TOTAL - 10'd1) ? vga_vcounter + 10'd1 : vga_vcounter;
    rd_addr    = {vn[1], next_pixel_x[8:1]};
    frame_mark = ppu_ce && (ppu_x == '0) && (ppu_y == FRAME_MARK_Y);
    match      = (vga_vcounter == V_TOTAL - 10'd1) && (vga_hcounter >= MATCH_H_MIN);
  end

  line_buffer_2x256 u_line_buffer (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (ppu_pixel),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_HUNT;
      sync_q   <= 1'b0;
      locked_q <= 1'b0;
      miss_q   <= '0;
      resync_q <= '0;
    end else begin
      sync_q <= 1'b0;
      case (state_q)
        ST_HUNT: begin
          locked_q <= 1'b0;
          if (frame_mark) begin
            state_q  <= ST_LOCKED;
            sync_q   <= 1'b1;
            locked_q <= 1'b1;
          end
        end
        ST_LOCKED: begin
          locked_q <= 1'b1;
          if (frame_mark) begin
            if (match) begin
              miss_q <= '0;
            end else if (miss_q != '0) begin
              // Second miss in a row: realign the driver, stay locked.
              sync_q <= 1'b1;
              miss_q <= '0;
              if (resync_q != '1) begin
                resync_q <= resync_q + 8'd1;
              end
            end else begin
              miss_q <= miss_q + 2'd1;
            end
          end
        end
        default: begin
          state_q  <= ST_HUNT;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCANLINE_DIM_EN
  logic dim_q;

  always_ff @(posedge clk) begin
    dim_q <= vn[0];
  end

  always_comb begin
    pixel_d = dim_q ? dim_pixel(rd_data) : rd_data;
  end
`else
  always_comb begin
    pixel_d = rd_data;
  end
`endif

  always_comb begin
    sync         = sync_q;
    locked       = locked_q;
    resync_count = resync_q;
    pixel        = locked_q ? pixel_d : '0;
    unused_bits  = ^{next_pixel_x[9], next_pixel_x[0], vn[9:2], vn[0]};
  end

endmodule

// File: tb/tb_scanline_sync_ctrl.sv
// Randomized bench for scanline_sync_ctrl against a frame-level reference model.
module tb_scanline_sync_ctrl;

  localparam int unsigned FRAME  = 357368;          // 262*341*4 == 524*682
  localparam int unsigned P_MARK = 341 * 4 + 3;     // clock of the ce for dot (0,1)
  localparam int unsigned Q_MARK = 523 * 682 + 676; // driver position at a well-aligned mark

  logic        clk = 1'b0;
  logic        reset;
  logic        ppu_ce;
  logic [8:0]  ppu_x;
  logic [8:0]  ppu_y;
  logic [14:0] ppu_pixel;
  logic [9:0]  vga_h;
  logic [9:0]  vga_v;
  logic [9:0]  npx;
  logic        sync;
  logic [14:0] pixel;
  logic        locked;
  logic [7:0]  resync_count;

  always #5 clk = ~clk;

  scanline_sync_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .ppu_ce       (ppu_ce),
    .ppu_x        (ppu_x),
    .ppu_y        (ppu_y),
    .ppu_pixel    (ppu_pixel),
    .vga_hcounter (vga_h),
    .vga_vcounter (vga_v),
    .next_pixel_x (npx),
    .sync         (sync),
    .pixel        (pixel),
    .locked       (locked),
    .resync_count (resync_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          m_hunt = 1'b1;
  int          m_miss = 0;
  int          m_rc   = 0;
  bit          m_sync = 1'b0;
  logic [14:0] m_mem [2][256];
  bit          m_val [2][256];

  // Stimulus state: linear PPU clock p and driver position q, both modulo FRAME
  int unsigned p;
  int unsigned q;
  int          stall_n = 0;
  bit          ovr_en = 1'b0;
  logic [14:0] ovr [2];
  bit          realign_en = 1'b1;

  task automatic tick(input bit rst);
    int unsigned dot;
    int          vn;
    int          bank;
    int          addr;
    bit          fm;
    bit          mt;
    bit          pv;
    logic [14:0] pd;
    dot       = p / 4;
    ppu_ce    = (stall_n == 0) && (p % 4 == 3);
    ppu_x     = 9'(dot % 341);
    ppu_y     = 9'(dot / 341);
    ppu_pixel = (ovr_en && ppu_x == 9'd5 && ppu_y < 9'd2) ? ovr[ppu_y[0]] : 15'($urandom);
    vga_h     = 10'(q % 682);
    vga_v     = 10'(q / 682);
    npx       = 10'((q % 682 + 1) % 682);
    reset     = rst;

    vn   = (vga_h == 10'd681) ? int'(vga_v) + 1 : int'(vga_v);
    bank = (vn / 2) % 2;
    addr = (int'(npx) / 2) % 256;
    pv   = m_val[bank][addr];
    pd   = m_mem[bank][addr];
`ifdef SCANLINE_DIM_EN
    if (vn % 2 == 1)
      pd = 15'((((pd >> 10) & 31) >> 1) * 1024 + (((pd >> 5) & 31) >> 1) * 32 + ((pd & 31) >> 1));
`endif
    if (ppu_ce && ppu_x < 9'd256 && ppu_y < 9'd240) begin
      m_mem[ppu_y % 2][ppu_x % 256] = ppu_pixel;
      m_val[ppu_y % 2][ppu_x % 256] = 1'b1;
    end

    fm = ppu_ce && ppu_x == 9'd0 && ppu_y == 9'd1;
    mt = (vga_v == 10'd523) && (vga_h >= 10'd674);
    m_sync = 1'b0;
    if (rst) begin
      m_hunt = 1'b1;
      m_miss = 0;
      m_rc   = 0;
    end else if (fm) begin
      if (m_hunt) begin
        m_hunt = 1'b0;
        m_sync = 1'b1;
      end else if (mt) begin
        m_miss = 0;
      end else begin
        m_miss++;
        if (m_miss >= 2) begin
          m_sync = 1'b1;
          m_miss = 0;
          if (m_rc < 255) m_rc++;
        end
      end
    end

    @(posedge clk);
    #1;
    check_eq("sync", 32'(sync), 32'(m_sync));
    check_eq("locked", 32'(locked), 32'(!m_hunt));
    check_eq("resync_count", 32'(resync_count), 32'(m_rc));
    if (m_hunt) check_eq("pixel_blank", 32'(pixel), 32'd0);
    else if (pv) check_eq("pixel", 32'(pixel), 32'(pd));

    if (stall_n > 0) stall_n--;
    else p = (p + 1) % FRAME;
    q = (q + 1) % FRAME;
    // Bench-side VGA driver: snap to the aligned phase whenever told to
    if (realign_en && sync === 1'b1) q = (p + Q_MARK + FRAME - P_MARK) % FRAME;
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b0);
  endtask

  task automatic jump_p(input int unsigned newp);
    int unsigned delta;
    delta = (newp + FRAME - p) % FRAME;
    p = newp;
    q = (q + delta) % FRAME;
  endtask

  task automatic realign();
    q = (p + Q_MARK + FRAME - P_MARK) % FRAME;
  endtask

  task automatic set_mark_vga(input int unsigned v, input int unsigned h);
    q = (v * 682 + h + FRAME - 15) % FRAME;
  endtask

  task automatic frame();
    jump_p(P_MARK - 15);
    run(20);
  endtask

  initial begin
    int unsigned r;
    p = (100 * 341 + 10) * 4;
    q = $urandom_range(0, FRAME - 1);
    ovr[0] = 15'h7C1F;
    ovr[1] = 15'h03E0;

    tick(1'b1);
    tick(1'b1);
    check_eq("reset_pixel", 32'(pixel), 32'd0);
    run(40);
    check_eq("hunt_locked", 32'(locked), 32'd0);

    frame();
    check_eq("first_lock", 32'(locked), 32'd1);
    check_eq("first_lock_rc", 32'(resync_count), 32'd0);

    repeat (10) frame();
    check_eq("steady_rc", 32'(resync_count), 32'd0);
    check_eq("steady_locked", 32'(locked), 32'd1);

    ovr_en = 1'b1;
    jump_p(0);
    run(341 * 4 + 40);
    ovr_en = 1'b0;
    for (int v = 0; v < 4; v++) begin
      for (int h = 10; h < 12; h++) begin
        q = 32'(v * 682 + h - 1);
        tick(1'b0);
        check_eq($sformatf("line_v%0d_h%0d", v, h), 32'(pixel),
                 (v < 2) ? 32'h7C1F : 32'h03E0);
      end
    end
    q = $urandom_range(0, 2 * 682 - 1);
    run(200);

    realign();
    frame();
    repeat (3) begin
      jump_p(P_MARK - 15);
      stall_n = 4;
      run(24);
    end
    check_eq("drop_rc", 32'(resync_count), 32'd1);
    check_eq("drop_locked", 32'(locked), 32'd1);
    frame();
    frame();
    check_eq("post_resync_rc", 32'(resync_count), 32'd1);

    repeat (12) begin
      jump_p(P_MARK - 15);
      r = $urandom_range(0, 3);
      if (r == 0) set_mark_vga($urandom_range(0, 522), $urandom_range(0, 681));
      else if (r == 1) set_mark_vga(523, $urandom_range(0, 673));
      else set_mark_vga(523, $urandom_range(674, 681));
      run(20);
    end

    jump_p((50 * 341 + 100) * 4);
    run(10);
    tick(1'b1);
    check_eq("midreset_locked", 32'(locked), 32'd0);
    check_eq("midreset_pixel", 32'(pixel), 32'd0);
    run(10);
    check_eq("midreset_hunt", 32'(locked), 32'd0);
    frame();
    check_eq("relock", 32'(locked), 32'd1);
    check_eq("relock_rc", 32'(resync_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
